// File: rtl/scratchpad.sv
// scratchpad: WEIGHT_COLS x WEIGHT_ROWS weight store, one column written and one column read per cycle.
// Ports: clk, rst_n, wr_en/wr_col/data_in, rd_en/rd_col -> data_out/out_valid, addr_err. Macro: SCRATCHPAD_FWD_EN (write-first).
module scratchpad #(
  parameter int WEIGHT_WIDTH = 5,
  parameter int WEIGHT_ROWS  = 6,
  parameter int WEIGHT_COLS  = 3,
  localparam int CW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_col,
  input  logic [WEIGHT_WIDTH-1:0] data_in  [0:WEIGHT_ROWS-1],
  input  logic                    rd_en,
  input  logic [CW-1:0]           rd_col,
  output logic [WEIGHT_WIDTH-1:0] data_out [0:WEIGHT_ROWS-1],
  output logic                    out_valid,
  output logic                    addr_err
);

  localparam logic [CW:0] LP_COLS = WEIGHT_COLS[CW:0];

  logic [WEIGHT_WIDTH-1:0] r_mem  [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
  logic [WEIGHT_WIDTH-1:0] r_data [0:WEIGHT_ROWS-1];
  logic                    r_valid;
  logic                    r_err;

  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic                    w_wr_bad;
  logic                    w_rd_bad;
  logic [WEIGHT_WIDTH-1:0] w_rd_data [0:WEIGHT_ROWS-1];

  assign w_wr_ok  = wr_en && ({1'b0, wr_col} < LP_COLS);
  assign w_rd_ok  = rd_en && ({1'b0, rd_col} < LP_COLS);
  assign w_wr_bad = wr_en && !({1'b0, wr_col} < LP_COLS);
  assign w_rd_bad = rd_en && !({1'b0, rd_col} < LP_COLS);

  // Out-of-range reads return zeros.
  always_comb begin
    for (int i = 0; i < WEIGHT_ROWS; i++) begin
      w_rd_data[i] = '0;
      if (w_rd_ok) begin
        w_rd_data[i] = r_mem[rd_col][i];
`ifdef SCRATCHPAD_FWD_EN
        if (w_wr_ok && (wr_col == rd_col)) begin
          w_rd_data[i] = data_in[i];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        for (int r = 0; r < WEIGHT_ROWS; r++) begin
          r_mem[c][r] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int r = 0; r < WEIGHT_ROWS; r++) begin
        r_mem[wr_col][r] <= data_in[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WEIGHT_ROWS; r++) begin
        r_data[r] <= '0;
      end
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (rd_en) begin
        for (int r = 0; r < WEIGHT_ROWS; r++) begin
          r_data[r] <= w_rd_data[r];
        end
      end
      r_valid <= rd_en;
      r_err   <= w_wr_bad || w_rd_bad;
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign addr_err  = r_err;

endmodule

// File: tb/tb_scratchpad.sv
// tb_scratchpad: randomized and directed checks of scratchpad against a column-level model.
// Default parameters 5/6/3; honours SCRATCHPAD_FWD_EN in the model.
module tb_scratchpad;
  localparam int W = 5;
  localparam int R = 6;
  localparam int C = 3;
  typedef logic [W-1:0] w_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [1:0] wr_col = '0;
  logic [1:0] rd_col = '0;
  w_t data_in  [0:R-1];
  w_t data_out [0:R-1];
  logic out_valid;
  logic addr_err;

  int tests = 0;
  int fails = 0;

  logic [R*W-1:0] mem_m [C];
  logic [R*W-1:0] exp_d;
  logic exp_v;
  logic exp_e;
  logic [R*W-1:0] dout_p;

  scratchpad dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_col(wr_col), .data_in(data_in),
    .rd_en(rd_en), .rd_col(rd_col), .data_out(data_out),
    .out_valid(out_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    dout_p = '0;
    for (int i = 0; i < R; i++) dout_p[i*W +: W] = data_out[i];
  end

  function automatic logic [R*W-1:0] pk(input int a0, a1, a2, a3, a4, a5);
    logic [R*W-1:0] v;
    v = {w_t'(a5), w_t'(a4), w_t'(a3), w_t'(a2), w_t'(a1), w_t'(a0)};
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < C; c++) mem_m[c] = '0;
    exp_d = '0;
    exp_v = 1'b0;
    exp_e = 1'b0;
  endtask

  task automatic step(input logic we, input int wc, input logic [R*W-1:0] d,
                      input logic re, input int rc);
    logic [R*W-1:0] rd;
    @(negedge clk);
    wr_en = we;
    wr_col = wc[1:0];
    rd_en = re;
    rd_col = rc[1:0];
    for (int i = 0; i < R; i++) data_in[i] = d[i*W +: W];
    @(posedge clk);
    exp_e = (we && wc >= C) || (re && rc >= C);
    exp_v = re;
    if (re) begin
      rd = '0;
      if (rc < C) rd = mem_m[rc];
`ifdef SCRATCHPAD_FWD_EN
      if (we && wc == rc && rc < C) rd = d;
`endif
      exp_d = rd;
    end
    if (we && wc < C) mem_m[wc] = d;
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b0 || addr_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_init got d=%h v=%b e=%b want 0/0/0", dout_p, out_valid, addr_err);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, '0, 1, 2);
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_rd2 got d=%h v=%b want 0/1", dout_p, out_valid);
    end
  endtask

  task automatic test_write_read();
    step(1, 0, pk(0, 1, 2, 3, 4, 5), 0, 0);
    step(0, 0, '0, 1, 0);
    tests++;
    if (dout_p !== pk(0, 1, 2, 3, 4, 5) || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL wr_rd got d=%h v=%b want %h/1", dout_p, out_valid, pk(0, 1, 2, 3, 4, 5));
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, pk(31, 30, 29, 28, 27, 26), 0, 0);
    step(1, 2, pk(7, 7, 7, 7, 7, 7), 0, 0);
    step(0, 0, '0, 1, 2);
    tests++;
    if (dout_p !== pk(7, 7, 7, 7, 7, 7) || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_c2 got d=%h v=%b", dout_p, out_valid);
    end
    step(0, 0, '0, 1, 1);
    tests++;
    if (dout_p !== pk(31, 30, 29, 28, 27, 26) || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_c1 got d=%h v=%b", dout_p, out_valid);
    end
    step(0, 0, '0, 1, 0);
    tests++;
    if (dout_p !== pk(0, 1, 2, 3, 4, 5) || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_c0 got d=%h v=%b", dout_p, out_valid);
    end
  endtask

  task automatic test_same_cycle();
    logic [R*W-1:0] want;
`ifdef SCRATCHPAD_FWD_EN
    want = pk(9, 9, 9, 9, 9, 9);
`else
    want = pk(31, 30, 29, 28, 27, 26);
`endif
    step(1, 1, pk(9, 9, 9, 9, 9, 9), 1, 1);
    tests++;
    if (dout_p !== want || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL same_cyc got d=%h v=%b want %h/1", dout_p, out_valid, want);
    end
    step(0, 0, '0, 1, 1);
    tests++;
    if (dout_p !== pk(9, 9, 9, 9, 9, 9)) begin
      fails++;
      $display("FAIL same_next got d=%h want %h", dout_p, pk(9, 9, 9, 9, 9, 9));
    end
  endtask

  task automatic test_out_of_range();
    step(1, 3, pk(1, 2, 3, 4, 5, 6), 0, 0);
    tests++;
    if (addr_err !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL oor_wr got e=%b v=%b want 1/0", addr_err, out_valid);
    end
    step(0, 0, '0, 0, 0);
    tests++;
    if (addr_err !== 1'b0) begin
      fails++;
      $display("FAIL oor_clear got e=%b want 0", addr_err);
    end
    for (int c = 0; c < C; c++) begin
      step(0, 0, '0, 1, c);
      tests++;
      if (dout_p !== exp_d || addr_err !== 1'b0) begin
        fails++;
        $display("FAIL oor_keep c%0d got d=%h e=%b want %h/0", c, dout_p, addr_err, exp_d);
      end
    end
    step(0, 0, '0, 1, 3);
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b1 || addr_err !== 1'b1) begin
      fails++;
      $display("FAIL oor_rd got d=%h v=%b e=%b want 0/1/1", dout_p, out_valid, addr_err);
    end
  endtask

  task automatic test_rd_idle();
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    tests++;
    if (out_valid !== 1'b0 || dout_p !== pk(0, 1, 2, 3, 4, 5)) begin
      fails++;
      $display("FAIL rd_idle got d=%h v=%b want %h/0", dout_p, out_valid, pk(0, 1, 2, 3, 4, 5));
    end
  endtask

  task automatic test_random();
    logic [31:0] r0;
    logic [31:0] r1;
    for (int n = 0; n < 300; n++) begin
      r0 = $urandom;
      r1 = $urandom;
      step(r1[0], int'($urandom_range(0, 3)), r0[R*W-1:0],
           r1[1] | r1[2], int'($urandom_range(0, 3)));
      tests++;
      if (dout_p !== exp_d || out_valid !== exp_v || addr_err !== exp_e) begin
        fails++;
        $display("FAIL rand n%0d got d=%h v=%b e=%b want %h/%b/%b",
                 n, dout_p, out_valid, addr_err, exp_d, exp_v, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 2, pk(3, 3, 3, 3, 3, 3), 0, 0);
    step(0, 0, '0, 1, 2);
    @(negedge clk);
    wr_en = 1'b1;
    wr_col = 2'd0;
    rd_en = 1'b1;
    rd_col = 2'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b0 || addr_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got d=%h v=%b e=%b want 0/0/0", dout_p, out_valid, addr_err);
    end
    @(posedge clk);
    #1;
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold got d=%h v=%b want 0/0", dout_p, out_valid);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b1;
    step(0, 0, '0, 1, 2);
    tests++;
    if (dout_p !== '0 || out_valid !== 1'b1 || addr_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_rd got d=%h v=%b e=%b want 0/1/0", dout_p, out_valid, addr_err);
    end
  endtask

  initial begin
    for (int i = 0; i < R; i++) data_in[i] = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_same_cycle();
    test_out_of_range();
    test_rd_idle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scratchpad.md
# scratchpad

Weight scratchpad for the processing-element array: a WEIGHT_ROWS × WEIGHT_COLS register array of WEIGHT_WIDTH-bit weights. A full column of WEIGHT_ROWS weights is written in one cycle and a full column is read in one cycle, so the PE row lanes get one weight each per cycle. It sits between the weight loader (write side) and the PE array (read side).

## Interface
Parameters:
- WEIGHT_WIDTH, 5, bits per weight.
- WEIGHT_ROWS, 6, weights per column; also the lane count of data_in and data_out.
- WEIGHT_COLS, 3, number of stored columns.
- CW (localparam), WEIGHT_COLS>1 ? $clog2(WEIGHT_COLS) : 1, column-index width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write data_in into column wr_col.
- wr_col  in  CW  write column index.
- data_in  in  [WEIGHT_WIDTH-1:0] × [0:WEIGHT_ROWS-1]  unpacked array; lane i is the weight for row i.
- rd_en  in  1  read column rd_col.
- rd_col  in  CW  read column index.
- data_out  out  [WEIGHT_WIDTH-1:0] × [0:WEIGHT_ROWS-1]  registered read data; lane i is row i.
- out_valid  out  1  data_out holds the result of a read accepted on the previous edge.
- addr_err  out  1  registered; high for one cycle after an out-of-range wr_col or rd_col is used with its enable.

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Storage is mem[col][row], WEIGHT_WIDTH bits per entry, WEIGHT_COLS × WEIGHT_ROWS entries.
- Write: when wr_en=1 and wr_col < WEIGHT_COLS, mem[wr_col][i] <= data_in[i] for every i. A write with wr_col ≥ WEIGHT_COLS changes no storage and sets addr_err.
- Read: when rd_en=1 and rd_col < WEIGHT_COLS, data_out[i] <= mem[rd_col][i] and out_valid <= 1.
  - A read with rd_col ≥ WEIGHT_COLS loads data_out with all zeros, sets out_valid=1 and sets addr_err.
- When rd_en=0: out_valid <= 0 and data_out keeps its last value.
- Simultaneous write and read of the same valid column: behaviour is set by the Configuration macro.
- Simultaneous write and read of different columns are independent.
- Lane order is preserved: data_in[i] always maps to data_out[i]. There is no transposition or reordering.
- Widths: data is stored unmodified, with no sign or zero extension.

## Timing
- Write latency: 1 edge. Data written at edge N can be read by a read issued at edge N+1, and appears on data_out after edge N+1.
- Read latency: 1 cycle. rd_en sampled at edge N gives data_out/out_valid valid after edge N.
- Back-to-back reads, one per cycle, are supported. out_valid stays high continuously while rd_en stays high.
- Reset (assert at any time, including mid-operation): all mem entries = 0, data_out = all 0, out_valid = 0, addr_err = 0, immediately and asynchronously.
  - The first edge after rst_n deasserts acts normally on its inputs.
- addr_err is recomputed every edge; it is not sticky.

## Configuration
- SCRATCHPAD_FWD_EN defined: write-first behaviour. A read of column c in the same cycle as a write of column c returns the new data_in on data_out.
- Not defined: read-first behaviour. The same case returns the old mem contents; the new data is visible from the next read onward.
- Either way, the write always lands in storage.

## Test plan
All scenarios use default parameters (5/6/3).
- Reset: drive rst_n=0 mid-stream -> data_out = {0,0,0,0,0,0}, out_valid=0, addr_err=0; a read of col 2 after release returns all 0.
- Write col 0 with data_in={0,1,2,3,4,5}, then read col 0 -> data_out={0,1,2,3,4,5} one cycle later, out_valid=1.
- Write col 1={31,30,29,28,27,26} and col 2={7,7,7,7,7,7}, then read cols 2,1,0 back-to-back -> three consecutive valid outputs in that order, col 0 unchanged.
- Same-cycle write col 1={9,9,9,9,9,9} while reading col 1 that holds {31,…,26}:
  - with SCRATCHPAD_FWD_EN -> data_out={9,…}.
  - without it -> data_out={31,30,29,28,27,26}; the next read returns {9,…}.
- Out of range: write col 3 -> storage unchanged, addr_err=1 for one cycle; read col 3 -> data_out all 0, out_valid=1, addr_err=1.
- rd_en=0 after a read -> out_valid=0, data_out holds its previous value.
